// File: rtl/gin_feeder_pkg.sv
// Shared widths and FSM encoding for the global interconnect feeder.
package gin_feeder_pkg;

  localparam int DATA_BITS   = 8;
  localparam int XID_BITS    = 4;
  localparam int NUMS_PE_COL = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/gin_feeder_fifo.sv
// Show-ahead synchronous FIFO: the head entry is readable combinationally
// while the FIFO is non-empty.
module gin_feeder_fifo #(
  parameter int WIDTH      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [WIDTH-1:0]                  wdata,
  input  logic                              pop,
  output logic [WIDTH-1:0]                  rdata,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gin_feeder.sv
// Global interconnect feeder: loads the multicast ID scan chain, then streams
// tagged beats from a small FIFO to the bus master port.
module gin_feeder
  import gin_feeder_pkg::*;
#(
  parameter int NUMS_SLAVE = NUMS_PE_COL,
  parameter int ID_SIZE    = XID_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cfg_start,
  input  logic                             cfg_id_valid,
  input  logic [ID_SIZE-1:0]               cfg_id,
  output logic                             cfg_id_ready,
  output logic                             cfg_done,
  input  logic                             in_valid,
  input  logic [ID_SIZE-1:0]               in_tag,
  input  logic [DATA_BITS-1:0]             in_data,
  output logic                             in_ready,
  output logic [ID_SIZE-1:0]               tag,
  output logic                             master_valid,
  output logic [DATA_BITS-1:0]             master_data,
  input  logic                             master_ready,
  output logic                             set_id,
  output logic [ID_SIZE-1:0]               ID_scan_in,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

  localparam int IDC_W = (NUMS_SLAVE > 1) ? $clog2(NUMS_SLAVE) : 1;
  localparam logic [IDC_W-1:0] LAST_ID = IDC_W'(NUMS_SLAVE - 1);
  localparam int W = ID_SIZE + DATA_BITS;

  state_e             state_q, state_d;
  logic [IDC_W-1:0]   id_cnt_q, id_cnt_d;
  logic               cfg_done_q, cfg_done_d;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [W-1:0]       fifo_head;

  gin_feeder_fifo #(
    .WIDTH      (W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata ({in_tag, in_data}),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    id_cnt_d     = id_cnt_q;
    cfg_done_d   = 1'b0;
    cfg_id_ready = 1'b0;
    set_id       = 1'b0;
    ID_scan_in   = '0;
    in_ready     = 1'b0;
    master_valid = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        cfg_id_ready = 1'b1;
        set_id       = cfg_id_valid;
        ID_scan_in   = cfg_id;
        if (cfg_id_valid) begin
          if (id_cnt_q == LAST_ID) begin
            state_d    = ST_RUN;
            id_cnt_d   = '0;
            cfg_done_d = 1'b1;
          end else begin
            id_cnt_d = id_cnt_q + 1'b1;
          end
        end
      end
      ST_RUN: begin
        // Full is taken from the registered count, so a pop never frees a slot early.
        in_ready     = !fifo_full;
        master_valid = !fifo_empty;
        fifo_push    = in_valid && !fifo_full;
        fifo_pop     = !fifo_empty && master_ready;
        if (cfg_start) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        master_valid = !fifo_empty;
        fifo_pop     = !fifo_empty && master_ready;
        if (fifo_empty) state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_cnt_q   <= '0;
      cfg_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_cnt_q   <= id_cnt_d;
      cfg_done_q <= cfg_done_d;
    end
  end

  // Head fields read as zero while nothing is offered to the bus.
  assign tag         = master_valid ? fifo_head[W-1:DATA_BITS] : '0;
  assign master_data = master_valid ? fifo_head[DATA_BITS-1:0] : '0;
  assign cfg_done    = cfg_done_q;
  assign busy        = (state_q != ST_RUN);

endmodule

// File: tb/tb_gin_feeder.sv
// Bench for gin_feeder: vector tables for the ID load and the backpressured
// stream, hand sequences for drain/reset corners, and a beat scoreboard.
module tb_gin_feeder;
  import gin_feeder_pkg::*;

  localparam int NS  = NUMS_PE_COL;
  localparam int IDW = XID_BITS;
  localparam int DW  = DATA_BITS;
  localparam int FD  = 4;
  localparam int CW  = $clog2(FD + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_start = 1'b0;
  logic           cfg_id_valid = 1'b0;
  logic [IDW-1:0] cfg_id = '0;
  logic           cfg_id_ready, cfg_done;
  logic           in_valid = 1'b0;
  logic [IDW-1:0] in_tag = '0;
  logic [DW-1:0]  in_data = '0;
  logic           in_ready;
  logic [IDW-1:0] tag;
  logic           master_valid;
  logic [DW-1:0]  master_data;
  logic           master_ready = 1'b0;
  logic           set_id;
  logic [IDW-1:0] ID_scan_in;
  logic           busy;
  logic [CW-1:0]  fifo_count;

  gin_feeder #(.NUMS_SLAVE(NS), .ID_SIZE(IDW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_id_valid(cfg_id_valid),
    .cfg_id(cfg_id), .cfg_id_ready(cfg_id_ready), .cfg_done(cfg_done),
    .in_valid(in_valid), .in_tag(in_tag), .in_data(in_data), .in_ready(in_ready),
    .tag(tag), .master_valid(master_valid), .master_data(master_data),
    .master_ready(master_ready), .set_id(set_id), .ID_scan_in(ID_scan_in),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [IDW+DW-1:0] sb_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ids();
    for (int i = NS - 1; i >= 0; i--) begin
      cfg_id_valid = 1'b1;
      cfg_id       = IDW'(i);
      tick();
    end
    cfg_id_valid = 1'b0;
    cfg_id       = '0;
  endtask

  // Scoreboard: accepted beats are queued, bus handshakes must match in order.
  always @(negedge clk) begin
    logic [IDW+DW-1:0] exp_beat;
    if (rst) begin
      sb_q.delete();
    end else begin
      if (master_valid && master_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got beat 0x%0h, expected no beat", {tag, master_data});
        end else begin
          exp_beat = sb_q.pop_front();
          check("sb_beat", 32'({tag, master_data}), 32'(exp_beat));
          $display("beat out tag=%0d data=0x%0h", tag, master_data);
        end
      end
      if (in_valid && in_ready) sb_q.push_back({in_tag, in_data});
    end
  end

  typedef struct {
    logic           vld;
    logic [IDW-1:0] id;
    logic           exp_set;
    logic [IDW-1:0] exp_scan;
  } ld_vec_t;

  typedef struct {
    logic           vld;
    logic [IDW-1:0] tg;
    logic [DW-1:0]  dt;
    logic           mr;
    logic           exp_ir;
    logic [CW-1:0]  exp_cnt;
    logic           exp_mv;
    logic [IDW-1:0] exp_tag;
  } st_vec_t;

  ld_vec_t ld_tab [7];
  st_vec_t st_tab [13];

  initial begin
    int sid_cycles;
    int k;

    ld_tab[0] = '{1'b1, 4'd5, 1'b1, 4'd5};
    ld_tab[1] = '{1'b1, 4'd4, 1'b1, 4'd4};
    ld_tab[2] = '{1'b1, 4'd3, 1'b1, 4'd3};
    ld_tab[3] = '{1'b0, 4'd0, 1'b0, 4'd0};
    ld_tab[4] = '{1'b1, 4'd2, 1'b1, 4'd2};
    ld_tab[5] = '{1'b1, 4'd1, 1'b1, 4'd1};
    ld_tab[6] = '{1'b1, 4'd0, 1'b1, 4'd0};

    st_tab[0]  = '{1'b1, 4'd1, 8'hA0, 1'b0, 1'b1, 3'd0, 1'b0, 4'd0};
    st_tab[1]  = '{1'b1, 4'd2, 8'hA1, 1'b0, 1'b1, 3'd1, 1'b1, 4'd1};
    st_tab[2]  = '{1'b1, 4'd3, 8'hA2, 1'b0, 1'b1, 3'd2, 1'b1, 4'd1};
    st_tab[3]  = '{1'b1, 4'd4, 8'hA3, 1'b0, 1'b1, 3'd3, 1'b1, 4'd1};
    st_tab[4]  = '{1'b1, 4'd5, 8'hA4, 1'b0, 1'b0, 3'd4, 1'b1, 4'd1};
    st_tab[5]  = '{1'b1, 4'd5, 8'hA4, 1'b0, 1'b0, 3'd4, 1'b1, 4'd1};
    st_tab[6]  = '{1'b1, 4'd5, 8'hA4, 1'b1, 1'b0, 3'd4, 1'b1, 4'd1};
    st_tab[7]  = '{1'b1, 4'd5, 8'hA4, 1'b1, 1'b1, 3'd3, 1'b1, 4'd2};
    st_tab[8]  = '{1'b1, 4'd6, 8'hA5, 1'b1, 1'b1, 3'd3, 1'b1, 4'd3};
    st_tab[9]  = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd3, 1'b1, 4'd4};
    st_tab[10] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd2, 1'b1, 4'd5};
    st_tab[11] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd1, 1'b1, 4'd6};
    st_tab[12] = '{1'b0, 4'd0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 4'd0};

    // Reset with in_valid held high, then idle: nothing may be accepted.
    rst = 1'b1; in_valid = 1'b1; in_tag = 4'd3; in_data = 8'h33;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("rst_in_ready", 32'(in_ready), 0);
      check("rst_mvalid", 32'(master_valid), 0);
      check("rst_busy", 32'(busy), 1);
      check("rst_outs", 32'({cfg_id_ready, cfg_done, set_id, ID_scan_in, fifo_count}), 0);
      check("rst_head", 32'({tag, master_data}), 0);
    end
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      check("idle_in_ready", 32'(in_ready), 0);
      check("idle_mvalid", 32'(master_valid), 0);
      check("idle_busy", 32'(busy), 1);
      $display("idle cycle %0d in_ready=%0d busy=%0d", c, in_ready, busy);
    end
    in_valid = 1'b0;

    // ID load from the vector table, with one valid gap.
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    sid_cycles = 0;
    for (int i = 0; i < 7; i++) begin
      cfg_id_valid = ld_tab[i].vld;
      cfg_id       = ld_tab[i].id;
      #1;
      check("ld_ready", 32'(cfg_id_ready), 1);
      check("ld_set_id", 32'(set_id), 32'(ld_tab[i].exp_set));
      check("ld_scan", 32'(ID_scan_in), 32'(ld_tab[i].exp_scan));
      check("ld_done_low", 32'(cfg_done), 0);
      if (set_id) sid_cycles++;
      $display("load row %0d valid=%0d id=%0d set_id=%0d scan=%0d", i, cfg_id_valid, cfg_id, set_id, ID_scan_in);
      tick();
    end
    cfg_id_valid = 1'b0; cfg_id = '0;
    #1;
    check("ld_sid_cycles", 32'(sid_cycles), 6);
    check("ld_done_pulse", 32'(cfg_done), 1);
    check("ld_busy_fall", 32'(busy), 0);
    check("run_cfg_ready", 32'(cfg_id_ready), 0);
    check("run_set_id", 32'(set_id), 0);
    tick();
    check("ld_done_once", 32'(cfg_done), 0);

    // Backpressured stream from the vector table.
    for (int i = 0; i < 13; i++) begin
      in_valid     = st_tab[i].vld;
      in_tag       = st_tab[i].tg;
      in_data      = st_tab[i].dt;
      master_ready = st_tab[i].mr;
      #1;
      check("st_in_ready", 32'(in_ready), 32'(st_tab[i].exp_ir));
      check("st_count", 32'(fifo_count), 32'(st_tab[i].exp_cnt));
      check("st_mvalid", 32'(master_valid), 32'(st_tab[i].exp_mv));
      check("st_head_tag", 32'(tag), 32'(st_tab[i].exp_tag));
      $display("stream row %0d in_ready=%0d count=%0d mvalid=%0d tag=%0d", i, in_ready, fifo_count, master_valid, tag);
      tick();
    end

    // Steady push and pop at occupancy 2.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_tag = IDW'(7 + i); in_data = DW'(8'hB0 + i);
      master_ready = (i >= 2);
      #1;
      check("pp_count", 32'(fifo_count), (i < 2) ? i : 2);
      if (i >= 2) begin
        check("pp_mvalid", 32'(master_valid), 1);
        check("pp_in_ready", 32'(in_ready), 1);
      end
      $display("push+pop cycle %0d count=%0d", i, fifo_count);
      tick();
    end
    in_valid = 1'b0; master_ready = 1'b1;
    #1;
    k = 0;
    while (master_valid && k < 8) begin
      tick(); #1; k++;
    end
    check("pp_drained", 32'(fifo_count), 0);

    // Reconfigure with 3 beats buffered.
    master_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = IDW'(1 + i); in_data = DW'(8'hC0 + i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("rc_count3", 32'(fifo_count), 3);
    cfg_start = 1'b1; master_ready = 1'b1;
    tick();
    cfg_start = 1'b0;
    in_valid = 1'b1; in_tag = 4'hE; in_data = 8'hEE;
    cfg_id_valid = 1'b1; cfg_id = 4'd7;
    for (int j = 0; j < 3; j++) begin
      #1;
      check("rc_in_ready", 32'(in_ready), 0);
      check("rc_set_id", 32'(set_id), 0);
      check("rc_cfg_ready", 32'(cfg_id_ready), 0);
      check("rc_count", 32'(fifo_count), 2 - j);
      check("rc_busy", 32'(busy), 1);
      $display("drain cycle %0d count=%0d mvalid=%0d", j, fifo_count, master_valid);
      tick();
    end
    #1;
    check("rc_load_ready", 32'(cfg_id_ready), 1);
    check("rc_load_set_id", 32'(set_id), 1);
    check("rc_load_scan", 32'(ID_scan_in), 7);
    cfg_id_valid = 1'b0; cfg_id = '0; in_valid = 1'b0;
    #1;

    // Reset after two IDs: the following load needs all six.
    for (int i = 0; i < 2; i++) begin
      cfg_id_valid = 1'b1; cfg_id = IDW'(5 - i);
      tick();
    end
    cfg_id_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rl_idle_ready", 32'(cfg_id_ready), 0);
    check("rl_busy", 32'(busy), 1);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int i = NS - 1; i >= 1; i--) begin
      cfg_id_valid = 1'b1; cfg_id = IDW'(i);
      tick();
      check("rl_partial_done", 32'(cfg_done), 0);
      check("rl_partial_busy", 32'(busy), 1);
    end
    cfg_id_valid = 1'b1; cfg_id = '0;
    tick();
    cfg_id_valid = 1'b0;
    check("rl_done", 32'(cfg_done), 1);
    check("rl_run", 32'(busy), 0);
    $display("reload after reset: done=%0d busy=%0d", cfg_done, busy);

    // Reset with 3 beats buffered: they must never reach the bus.
    master_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_tag = IDW'(3 + i); in_data = DW'(8'hD0 + i);
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("rf_count3", 32'(fifo_count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rf_count0", 32'(fifo_count), 0);
    check("rf_mvalid", 32'(master_valid), 0);
    master_ready = 1'b1;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    load_ids();
    check("rf_done", 32'(cfg_done), 1);
    #1;
    check("rf_empty_after_load", 32'({master_valid, fifo_count}), 0);
    in_valid = 1'b1; in_tag = 4'd9; in_data = 8'hDD;
    tick();
    in_valid = 1'b0;
    #1;
    check("rf_new_valid", 32'(master_valid), 1);
    check("rf_new_beat", 32'({tag, master_data}), 32'({4'd9, 8'hDD}));
    tick();
    check("rf_after_pop", 32'(master_valid), 0);
    check("sb_empty", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
